// File: rtl/sw_fanin_pkg.sv
// Shared sizing, index type and wrap helper for the fan-in merger.
package sw_fanin_pkg;

  localparam int DEF_N_SRC  = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

  localparam int IDX_W =
    (DEF_N_SRC > 1) ? $clog2(DEF_N_SRC) : 1;

  typedef logic [IDX_W-1:0] src_idx_t;

  // Wraps at the source count, not at 2^IDX_W.
  function automatic src_idx_t next_idx(
    input src_idx_t i
  );
    if (i == src_idx_t'(DEF_N_SRC - 1))
      return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/sw_rr_pick.sv
// Round-robin pick: first valid index at or after ptr,
// wrapping, found by a lowest-set-bit scan of a doubled vector.
module sw_rr_pick #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          grant_vld,
  output logic [IW-1:0] grant_idx
);

  logic [2*N-1:0] dbl;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dbl[i]     = valid[i] && (i >= int'(ptr));
      dbl[N + i] = valid[i];
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(j % N);
      end
    end
  end

endmodule

// File: rtl/sw_fanin_rr_merger.sv
// Round-robin fan-in of N_SRC child streams into one
// registered, source-tagged output with a saturating counter.
module sw_fanin_rr_merger
  import sw_fanin_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int SRC_IW =
    (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_IW-1:0]       out_src,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        fwd_count
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SRC_IW-1:0] out_src_q, out_src_d;
  logic [SRC_IW-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_vld;
  logic [SRC_IW-1:0] grant_idx;
  logic [SRC_IW-1:0] grant_nxt;
  logic              take;
  logic              xfer;
  logic              drain;

  sw_rr_pick #(
    .N  (N_SRC),
    .IW (SRC_IW)
  ) u_pick (
    .valid     (src_valid),
    .ptr       (ptr_q),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  if (N_SRC == DEF_N_SRC) begin : g_pkg_wrap
    assign grant_nxt =
      SRC_IW'(next_idx(src_idx_t'(grant_idx)));
  end else begin : g_gen_wrap
    assign grant_nxt =
      (grant_idx == SRC_IW'(N_SRC - 1)) ?
      '0 : grant_idx + 1'b1;
  end

  assign take  = !out_valid_q || out_ready;
  assign xfer  = take && grant_vld;
  assign drain = out_valid_q && out_ready;

  assign src_ready =
    xfer ? (N_SRC'(1) << grant_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  =
        src_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_src_d   = grant_idx;
      ptr_d       = grant_nxt;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    if (drain && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign fwd_count = cnt_q;

endmodule
